// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
//   arb_state_e : arbiter FSM states
//   bus_req_t   : request fields held on the memory port while a request is outstanding
//   starve_cnt_width() : width of the starvation counter for a given limit
package mem_port_arbiter_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned CntWidth  = 32;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StReqIf   = 3'd1,
        StReqMem  = 3'd2,
        StRespIf  = 3'd3,
        StRespMem = 3'd4
    } arb_state_e;

    typedef struct packed {
        logic                 wen;
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] wdata;
        logic [StrbWidth-1:0] wstrb;
    } bus_req_t;

    // Enough bits to hold 0..limit; limit is expected to be >= 1.
    function automatic int unsigned starve_cnt_width(int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle around the memory port arbiter: IF requester, MEM requester, external memory
// port, pipeline cancel and the conflict performance counter.
//   modport master : the arbiter itself (it owns the external memory port)
//   modport slave  : the surroundings (IF stage, MEM stage, memory)
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic                 cancel;

    logic                 IF_req_valid;
    logic [AddrWidth-1:0] IF_addr;
    logic                 IF_req_ready;
    logic                 IF_resp_valid;
    logic [DataWidth-1:0] IF_rdata;
    logic                 IF_resp_ready;

    logic                 MEM_req_valid;
    logic                 MEM_wen;
    logic [AddrWidth-1:0] MEM_addr;
    logic [DataWidth-1:0] MEM_wdata;
    logic [StrbWidth-1:0] MEM_wstrb;
    logic                 MEM_req_ready;
    logic                 MEM_resp_valid;
    logic [DataWidth-1:0] MEM_rdata;
    logic                 MEM_resp_ready;

    logic                 bus_req_valid;
    logic                 bus_req_ready;
    logic                 bus_wen;
    logic [AddrWidth-1:0] bus_addr;
    logic [DataWidth-1:0] bus_wdata;
    logic [StrbWidth-1:0] bus_wstrb;
    logic [DataWidth-1:0] bus_rdata;
    logic                 bus_rdata_valid;
    logic                 bus_rdata_ready;

    logic [CntWidth-1:0]  Arb_conflict_cnt;

    modport master (
        input  cancel,
        input  IF_req_valid, IF_addr, IF_resp_ready,
        output IF_req_ready, IF_resp_valid, IF_rdata,
        input  MEM_req_valid, MEM_wen, MEM_addr, MEM_wdata, MEM_wstrb, MEM_resp_ready,
        output MEM_req_ready, MEM_resp_valid, MEM_rdata,
        output bus_req_valid, bus_wen, bus_addr, bus_wdata, bus_wstrb, bus_rdata_ready,
        input  bus_req_ready, bus_rdata, bus_rdata_valid,
        output Arb_conflict_cnt
    );

    modport slave (
        output cancel,
        output IF_req_valid, IF_addr, IF_resp_ready,
        input  IF_req_ready, IF_resp_valid, IF_rdata,
        output MEM_req_valid, MEM_wen, MEM_addr, MEM_wdata, MEM_wstrb, MEM_resp_ready,
        input  MEM_req_ready, MEM_resp_valid, MEM_rdata,
        input  bus_req_valid, bus_wen, bus_addr, bus_wdata, bus_wstrb, bus_rdata_ready,
        output bus_req_ready, bus_rdata, bus_rdata_valid,
        input  Arb_conflict_cnt
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port between instruction fetch (IF) and load/store (MEM).
// One transaction at a time: IDLE grant -> REQ (held until bus_req_ready) -> RESP (reads only).
// MEM wins contention unless IF has lost STARVE_LIMIT contended arbitrations in a row.
// A fetch cancelled while in flight still completes on the bus; its read data is swallowed.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   port : mem_port_arbiter_if.master bundle (IF/MEM requesters, memory port, cancel, perf count)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.master port
);

    localparam int unsigned               StarveWidth = starve_cnt_width(STARVE_LIMIT);
    localparam logic [StarveWidth-1:0] StarveMax   = StarveWidth'(STARVE_LIMIT);

    arb_state_e             state_q, state_d;
    logic                   drop_q, drop_d;
    logic [StarveWidth-1:0] starve_q, starve_d;
    logic [CntWidth-1:0]    conflict_q, conflict_d;
    bus_req_t               bus_q, bus_d;

    logic grant_if;
    logic grant_mem;
    logic dropping;
    logic rdata_ack;

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        starve_d   = starve_q;
        conflict_d = conflict_q;
        bus_d      = bus_q;
        grant_if   = 1'b0;
        grant_mem  = 1'b0;
        dropping   = 1'b0;
        rdata_ack  = 1'b0;

        port.IF_req_ready    = 1'b0;
        port.IF_resp_valid   = 1'b0;
        port.IF_rdata        = '0;
        port.MEM_req_ready   = 1'b0;
        port.MEM_resp_valid  = 1'b0;
        port.MEM_rdata       = '0;
        port.bus_req_valid   = 1'b0;
        port.bus_rdata_ready = 1'b0;

        unique case (state_q)
            StIdle: begin
                // No grants while reset is held so no requester sees a phantom handshake.
                if (!rst) begin
                    if (port.IF_req_valid && port.MEM_req_valid) begin
                        conflict_d = conflict_q + CntWidth'(1);
                    end
                    // A fetch raised in the same cycle as a flush is already dead.
                    if (port.IF_req_valid && !port.cancel &&
                        (!port.MEM_req_valid || starve_q == StarveMax)) begin
                        grant_if = 1'b1;
                    end else if (port.MEM_req_valid) begin
                        grant_mem = 1'b1;
                    end
                end

                if (grant_if) begin
                    port.IF_req_ready = 1'b1;
                    bus_d.wen         = 1'b0;
                    bus_d.addr        = port.IF_addr;
                    bus_d.wdata       = '0;
                    bus_d.wstrb       = '0;
                    starve_d          = '0;
                    drop_d            = 1'b0;
                    state_d           = StReqIf;
                end else if (grant_mem) begin
                    port.MEM_req_ready = 1'b1;
                    bus_d.wen          = port.MEM_wen;
                    bus_d.addr         = port.MEM_addr;
                    bus_d.wdata        = port.MEM_wdata;
                    bus_d.wstrb        = port.MEM_wstrb;
                    if (port.IF_req_valid && starve_q != StarveMax) begin
                        starve_d = starve_q + StarveWidth'(1);
                    end
                    state_d = StReqMem;
                end
            end

            StReqIf: begin
                port.bus_req_valid = 1'b1;
                if (port.cancel) begin
                    drop_d = 1'b1;
                end
                if (port.bus_req_ready) begin
                    state_d = StRespIf;
                end
            end

            StReqMem: begin
                port.bus_req_valid = 1'b1;
                if (port.bus_req_ready) begin
                    state_d = bus_q.wen ? StIdle : StRespMem;
                end
            end

            StRespIf: begin
                // A flush arriving together with the data must not leak it to the pipeline.
                dropping             = drop_q || port.cancel;
                port.IF_rdata        = port.bus_rdata;
                port.IF_resp_valid   = port.bus_rdata_valid && !dropping;
                port.bus_rdata_ready = dropping || port.IF_resp_ready;
                rdata_ack            = port.bus_rdata_valid && (dropping || port.IF_resp_ready);
                if (port.cancel) begin
                    drop_d = 1'b1;
                end
                if (rdata_ack) begin
                    drop_d  = 1'b0;
                    state_d = StIdle;
                end
            end

            StRespMem: begin
                port.MEM_rdata       = port.bus_rdata;
                port.MEM_resp_valid  = port.bus_rdata_valid;
                port.bus_rdata_ready = port.MEM_resp_ready;
                rdata_ack            = port.bus_rdata_valid && port.MEM_resp_ready;
                if (rdata_ack) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            drop_q     <= 1'b0;
            starve_q   <= '0;
            conflict_q <= '0;
            bus_q      <= '0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            starve_q   <= starve_d;
            conflict_q <= conflict_d;
            bus_q      <= bus_d;
        end
    end

    assign port.bus_wen          = bus_q.wen;
    assign port.bus_addr         = bus_q.addr;
    assign port.bus_wdata        = bus_q.wdata;
    assign port.bus_wstrb        = bus_q.wstrb;
    assign port.Arb_conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for single transactions plus hand-written
// sequences for starvation, cancelled fetch and mid-transaction reset.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if pif ();

    mem_port_arbiter #(
        .STARVE_LIMIT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .port(pif)
    );

    always #5 clk = ~clk;

    // stim = {cancel, IF_req_valid, MEM_req_valid, MEM_wen, bus_req_ready, bus_rdata_valid}
    // eflg = {IF_req_ready, MEM_req_ready, bus_req_valid, IF_resp_valid, MEM_resp_valid,
    //         bus_rdata_ready}
    typedef struct packed {
        logic [5:0]  stim;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [5:0]  eflg;
        logic        ewen;
        logic [31:0] eaddr;
        logic [31:0] erdata;
    } vec_t;

    localparam int NumVec = 18;
    vec_t vecs [NumVec];

    function automatic vec_t mk(logic [5:0] stim, logic [31:0] addr, logic [31:0] rdata,
                                logic [5:0] eflg, logic ewen, logic [31:0] eaddr,
                                logic [31:0] erdata);
        vec_t v;
        v.stim   = stim;
        v.addr   = addr;
        v.rdata  = rdata;
        v.eflg   = eflg;
        v.ewen   = ewen;
        v.eaddr  = eaddr;
        v.erdata = erdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        pif.cancel          = 1'b0;
        pif.IF_req_valid    = 1'b0;
        pif.IF_addr         = '0;
        pif.IF_resp_ready   = 1'b1;
        pif.MEM_req_valid   = 1'b0;
        pif.MEM_wen         = 1'b0;
        pif.MEM_addr        = '0;
        pif.MEM_wdata       = 32'hDEAD_BEEF;
        pif.MEM_wstrb       = 4'hF;
        pif.MEM_resp_ready  = 1'b1;
        pif.bus_req_ready   = 1'b0;
        pif.bus_rdata       = '0;
        pif.bus_rdata_valid = 1'b0;
    endtask

    function automatic logic [5:0] flags();
        return {pif.IF_req_ready, pif.MEM_req_ready, pif.bus_req_valid, pif.IF_resp_valid,
                pif.MEM_resp_valid, pif.bus_rdata_ready};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // IF fetch 0x100, one-cycle memory latency
        vecs[0]  = mk(6'b010000, 32'h100, 32'h0, 6'b100000, 1'b0, 32'h0, 32'h0);
        vecs[1]  = mk(6'b000010, 32'h0, 32'h0, 6'b001000, 1'b0, 32'h100, 32'h0);
        vecs[2]  = mk(6'b000001, 32'h0, 32'h13, 6'b000101, 1'b0, 32'h0, 32'h13);
        vecs[3]  = mk(6'b000000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 32'h0);
        // fetch raised together with cancel is held off one cycle
        vecs[4]  = mk(6'b110000, 32'h200, 32'h0, 6'b000000, 1'b0, 32'h0, 32'h0);
        vecs[5]  = mk(6'b010000, 32'h200, 32'h0, 6'b100000, 1'b0, 32'h0, 32'h0);
        vecs[6]  = mk(6'b000010, 32'h0, 32'h0, 6'b001000, 1'b0, 32'h200, 32'h0);
        vecs[7]  = mk(6'b000001, 32'h0, 32'hAAAA5555, 6'b000101, 1'b0, 32'h0, 32'hAAAA5555);
        // store 0x2000, memory stalls the request 3 cycles, no response phase
        vecs[8]  = mk(6'b001100, 32'h2000, 32'h0, 6'b010000, 1'b0, 32'h0, 32'h0);
        vecs[9]  = mk(6'b000000, 32'h0, 32'h0, 6'b001000, 1'b1, 32'h2000, 32'h0);
        vecs[10] = mk(6'b000000, 32'h0, 32'h0, 6'b001000, 1'b1, 32'h2000, 32'h0);
        vecs[11] = mk(6'b000000, 32'h0, 32'h0, 6'b001000, 1'b1, 32'h2000, 32'h0);
        vecs[12] = mk(6'b000010, 32'h0, 32'h0, 6'b001000, 1'b1, 32'h2000, 32'h0);
        vecs[13] = mk(6'b000001, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 32'h0);
        // load 0x3000
        vecs[14] = mk(6'b001000, 32'h3000, 32'h0, 6'b010000, 1'b0, 32'h0, 32'h0);
        vecs[15] = mk(6'b000010, 32'h0, 32'h0, 6'b001000, 1'b0, 32'h3000, 32'h0);
        vecs[16] = mk(6'b000001, 32'h0, 32'h12345678, 6'b000011, 1'b0, 32'h0, 32'h12345678);
        vecs[17] = mk(6'b000000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 32'h0);

        // Reset
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sample();
        check("reset flags", 32'(flags()), 32'h0);
        check("reset bus_addr", pif.bus_addr, 32'h0);
        check("reset conflict_cnt", pif.Arb_conflict_cnt, 32'h0);

        // Vector table
        for (int i = 0; i < NumVec; i++) begin
            tick();
            clear_inputs();
            {pif.cancel, pif.IF_req_valid, pif.MEM_req_valid, pif.MEM_wen,
             pif.bus_req_ready, pif.bus_rdata_valid} = vecs[i].stim;
            pif.IF_addr   = vecs[i].addr;
            pif.MEM_addr  = vecs[i].addr;
            pif.bus_rdata = vecs[i].rdata;
            sample();
            check($sformatf("row%0d flags", i), 32'(flags()), 32'(vecs[i].eflg));
            if (vecs[i].eflg[3]) begin
                check($sformatf("row%0d bus_addr", i), pif.bus_addr, vecs[i].eaddr);
                check($sformatf("row%0d bus_wen", i), 32'(pif.bus_wen), 32'(vecs[i].ewen));
            end
            if (vecs[i].ewen) begin
                check($sformatf("row%0d bus_wdata", i), pif.bus_wdata, 32'hDEAD_BEEF);
                check($sformatf("row%0d bus_wstrb", i), 32'(pif.bus_wstrb), 32'hF);
            end
            if (vecs[i].eflg[2]) begin
                check($sformatf("row%0d IF_rdata", i), pif.IF_rdata, vecs[i].erdata);
            end
            if (vecs[i].eflg[1]) begin
                check($sformatf("row%0d MEM_rdata", i), pif.MEM_rdata, vecs[i].erdata);
            end
        end
        check("table conflict_cnt", pif.Arb_conflict_cnt, 32'h0);

        // Both requesters always valid: MEM x4 then IF, twice
        for (int t = 0; t < 10; t++) begin
            tick();
            if (t == 0) begin
                clear_inputs();
                pif.IF_req_valid    = 1'b1;
                pif.IF_addr         = 32'h4000;
                pif.MEM_req_valid   = 1'b1;
                pif.MEM_addr        = 32'h5000;
                pif.bus_req_ready   = 1'b1;
                pif.bus_rdata_valid = 1'b1;
                pif.bus_rdata       = 32'h0BAD_F00D;
            end
            sample();
            check($sformatf("starve grant%0d", t), 32'({pif.IF_req_ready, pif.MEM_req_ready}),
                  (t == 4 || t == 9) ? 32'h2 : 32'h1);
            check($sformatf("starve conflict%0d", t), pif.Arb_conflict_cnt, 32'(t));
            tick();
            tick();
        end
        tick();
        clear_inputs();
        sample();
        check("starve conflict_final", pif.Arb_conflict_cnt, 32'd10);

        // Fetch cancelled in RESP_IF, read data stalled, then swallowed
        tick();
        pif.IF_req_valid = 1'b1;
        pif.IF_addr      = 32'h400;
        sample();
        check("cancel grant", 32'(pif.IF_req_ready), 32'h1);
        tick();
        pif.IF_req_valid  = 1'b0;
        pif.bus_req_ready = 1'b1;
        sample();
        check("cancel bus_addr", pif.bus_addr, 32'h400);
        tick();
        pif.bus_req_ready = 1'b0;
        pif.IF_resp_ready = 1'b0;
        pif.cancel        = 1'b1;
        sample();
        check("cancel resp_valid0", 32'(pif.IF_resp_valid), 32'h0);
        for (int s = 0; s < 2; s++) begin
            tick();
            pif.cancel = 1'b0;
            sample();
            check($sformatf("cancel stall%0d", s),
                  32'({pif.IF_resp_valid, pif.bus_rdata_ready}), 32'h1);
        end
        tick();
        pif.bus_rdata_valid = 1'b1;
        pif.bus_rdata       = 32'hBAD0_BAD0;
        sample();
        check("cancel swallow", 32'({pif.IF_resp_valid, pif.bus_rdata_ready}), 32'h1);
        tick();
        pif.bus_rdata_valid = 1'b0;
        pif.IF_resp_ready   = 1'b1;
        pif.IF_req_valid    = 1'b1;
        pif.IF_addr         = 32'h500;
        sample();
        check("cancel regrant", 32'(pif.IF_req_ready), 32'h1);
        tick();
        pif.IF_req_valid  = 1'b0;
        pif.bus_req_ready = 1'b1;
        sample();
        check("cancel regrant addr", pif.bus_addr, 32'h500);
        tick();
        pif.bus_req_ready   = 1'b0;
        pif.bus_rdata_valid = 1'b1;
        pif.bus_rdata       = 32'h600;
        sample();
        check("cancel next resp_valid", 32'(pif.IF_resp_valid), 32'h1);
        check("cancel next rdata", pif.IF_rdata, 32'h600);

        // Reset pulse while in RESP_MEM
        tick();
        clear_inputs();
        pif.MEM_req_valid = 1'b1;
        pif.MEM_addr      = 32'h700;
        sample();
        check("rst grant", 32'(pif.MEM_req_ready), 32'h1);
        tick();
        pif.MEM_req_valid = 1'b0;
        pif.bus_req_ready = 1'b1;
        sample();
        check("rst bus_valid", 32'(pif.bus_req_valid), 32'h1);
        tick();
        pif.bus_req_ready = 1'b0;
        sample();
        check("rst resp_mem rdata_ready", 32'(pif.bus_rdata_ready), 32'h1);
        tick();
        rst = 1'b1;
        tick();
        rst                 = 1'b0;
        pif.bus_rdata_valid = 1'b1;
        pif.bus_rdata       = 32'h777;
        sample();
        check("rst flags", 32'(flags()), 32'h0);
        check("rst bus_addr", pif.bus_addr, 32'h0);
        check("rst bus_wdata", pif.bus_wdata, 32'h0);
        check("rst bus_wstrb_wen", 32'({pif.bus_wen, pif.bus_wstrb}), 32'h0);
        check("rst conflict_cnt", pif.Arb_conflict_cnt, 32'h0);
        check("rst MEM_rdata", pif.MEM_rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
